// File: rtl/shift_r_iter_pkg.sv
// Shared definitions for the iterative right shifter.
package shift_r_iter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_r_stage.sv
// One conditional right-shift stage: shifts by 2^i_k with i_fill when enabled.
module shift_r_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned KW    = 3
) (
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_en,
    input  logic             i_fill,
    input  logic [KW-1:0]    i_k,
    output logic [WIDTH-1:0] o_word
);

    localparam int unsigned LOG_W = $clog2(WIDTH);

    logic [WIDTH-1:0] w_ones;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_mask;
    int unsigned      w_amt;

    assign w_ones = '1;

    // Any 2^k that reaches WIDTH is clamped so the word becomes pure fill.
    always_comb begin
        w_amt = WIDTH;
        if (32'(i_k) < LOG_W) begin
            w_amt = 32'd1 << i_k;
        end
        w_shift = i_word >> w_amt;
        w_mask  = ~(w_ones >> w_amt);
        o_word  = i_word;
        if (i_en) begin
            o_word = i_fill ? (w_shift | w_mask) : w_shift;
        end
    end

endmodule

// File: rtl/shift_r_iter.sv
// Iterative barrel shifter: one 2^k stage per cycle, valid/ready on both sides.
module shift_r_iter
    import shift_r_iter_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       A,
    input  logic [SHIFT_WIDTH-1:0] B,
    input  logic                   arith,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       Y,
    output logic                   busy
);

    localparam int unsigned    KW     = $clog2(SHIFT_WIDTH + 1);
    localparam logic [KW-1:0]  K_LAST = KW'(SHIFT_WIDTH);

    state_t                 r_state;
    state_t                 w_next;
    logic [WIDTH-1:0]       r_word;
    logic [WIDTH-1:0]       w_stage;
    logic [SHIFT_WIDTH-1:0] r_b;
    logic                   r_fill;
    logic [KW-1:0]          r_k;

    // r_b is consumed LSB-first, so bit 0 is always the enable for stage r_k.
    shift_r_stage #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_stage (
        .i_word (r_word),
        .i_en   (r_b[0]),
        .i_fill (r_fill),
        .i_k    (r_k),
        .o_word (w_stage)
    );

    // SHIFT runs SHIFT_WIDTH+1 cycles; the last one is a hold so latency is fixed.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)       w_next = SHIFT;
            SHIFT:   if (r_k == K_LAST)  w_next = DONE;
            DONE:    if (out_ready)      w_next = IDLE;
            default:                     w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_word  <= '0;
            r_b     <= '0;
            r_fill  <= 1'b0;
            r_k     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_word <= A;
                        r_b    <= B;
                        r_fill <= arith & A[WIDTH-1];
                        r_k    <= '0;
                    end
                end
                SHIFT: begin
                    r_word <= w_stage;
                    r_b    <= r_b >> 1;
                    r_k    <= r_k + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign Y         = r_word;

endmodule
